jtag_host: RTL and testbench



---
 rtl/jtag_host.sv | 200 ++++++++++++++++++++
 tb/tb_jtag_host.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_host.sv
// jtag_host: JTAG initiator that turns command packets into TCK/TMS/TDI sequences and returns captured TDO.
// Optional build macro JTAG_HOST_AUTO_RESET_EN runs a TAP reset sequence right after rst_ni release.
module jtag_host #(
  parameter  int unsigned CLK_DIV = 4,
  parameter  int unsigned MAX_LEN = 32,
  localparam int unsigned LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_type_i,
  input  logic [LW-1:0]      cmd_len_i,
  input  logic [MAX_LEN-1:0] cmd_data_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [MAX_LEN-1:0] rsp_data_o,
  output logic               busy_o,
  output logic               tck_o,
  output logic               tms_o,
  output logic               tdi_o,
  input  logic               tdo_i
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SHIFT, S_POST, S_RESP, S_DONE} state_e;

  localparam logic [1:0] CMD_RST  = 2'b00;
  localparam logic [1:0] CMD_IR   = 2'b01;
  localparam logic [1:0] CMD_DR   = 2'b10;
  localparam logic [1:0] CMD_IDLE = 2'b11;

  // TMS preambles, LSB emitted first
  localparam logic [5:0] PRE_RST = 6'b011111;
  localparam logic [5:0] PRE_IR  = 6'b000011;
  localparam logic [5:0] PRE_DR  = 6'b000001;

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

  state_e             state_q, state_d;
  logic [1:0]         type_q, type_d;
  logic [LW-1:0]      cnt_q, cnt_d;
  logic [LW-1:0]      len_q, len_d;
  logic [7:0]         div_q, div_d;
  logic               tck_q, tck_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic [5:0]         pre_q, pre_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic [LW-1:0]      len_eff;
  logic [LW-1:0]      idx;

  always_comb begin
    if (cmd_len_i == '0)                len_eff = LW'(1);
    else if (cmd_len_i > LW'(MAX_LEN)) len_eff = LW'(MAX_LEN);
    else                                len_eff = cmd_len_i;
  end

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    div_d       = div_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    pre_d       = pre_q;
    data_d      = data_q;
    cap_d       = cap_q;
    cmd_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    idx         = len_q - LW'(1) - cnt_q;
    case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          type_d = cmd_type_i;
          data_d = cmd_data_i;
          cap_d  = '0;
          len_d  = len_eff;
          div_d  = DIV_LOAD;
          tck_d  = 1'b0;
          case (cmd_type_i)
            CMD_RST: begin state_d = S_PRE; pre_d = PRE_RST; cnt_d = LW'(5); tms_d = 1'b1; end
            CMD_IR:  begin state_d = S_PRE; pre_d = PRE_IR;  cnt_d = LW'(3); tms_d = 1'b1; end
            CMD_DR:  begin state_d = S_PRE; pre_d = PRE_DR;  cnt_d = LW'(2); tms_d = 1'b1; end
            default: begin
              if (cmd_len_i == '0) begin
                state_d = S_DONE;
              end else begin
                state_d = S_SHIFT;
                cnt_d   = cmd_len_i - LW'(1);
                tms_d   = 1'b0;
                tdi_d   = cmd_data_i[0];
              end
            end
          endcase
        end
      end
      S_PRE, S_SHIFT, S_POST: begin
        if (div_q != 8'd0) begin
          div_d = div_q - 8'd1;
        end else begin
          div_d = DIV_LOAD;
          tck_d = ~tck_q;
          if (!tck_q) begin
            // rising edge of TCK: TDO is captured in this very cycle
            if (state_q == S_SHIFT && type_q != CMD_IDLE)
              cap_d = cap_q | ({{(MAX_LEN-1){1'b0}}, tdo_i} << idx);
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - LW'(1);
            case (state_q)
              S_PRE: begin
                pre_d = pre_q >> 1;
                tms_d = pre_q[1];
              end
              S_SHIFT: begin
                data_d = data_q >> 1;
                tdi_d  = data_q[1];
                tms_d  = (cnt_q == LW'(1)) && (type_q != CMD_IDLE);
              end
              default: tms_d = 1'b0;
            endcase
          end else begin
            case (state_q)
              S_PRE: begin
                if (type_q == CMD_RST) begin
                  state_d = S_DONE;
                end else begin
                  state_d = S_SHIFT;
                  cnt_d   = len_q - LW'(1);
                  tms_d   = (len_q == LW'(1));
                  tdi_d   = data_q[0];
                end
              end
              S_SHIFT: begin
                if (type_q == CMD_IDLE) begin
                  state_d = S_DONE;
                end else begin
                  state_d = S_POST;
                  cnt_d   = LW'(1);
                  tms_d   = 1'b1;
                  tdi_d   = 1'b0;
                end
              end
              default: state_d = S_RESP;
            endcase
          end
        end
      end
      S_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
`ifdef JTAG_HOST_AUTO_RESET_EN
      state_q <= S_PRE;
      pre_q   <= PRE_RST;
      cnt_q   <= LW'(5);
`else
      state_q <= S_IDLE;
      pre_q   <= '0;
      cnt_q   <= '0;
`endif
      type_q  <= CMD_RST;
      len_q   <= '0;
      div_q   <= DIV_LOAD;
      tck_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      data_q  <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      len_q   <= len_d;
      div_q   <= div_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      data_q  <= data_d;
      cap_q   <= cap_d;
    end
  end

  assign rsp_data_o = (state_q == S_RESP) ? cap_q : '0;
  assign busy_o     = (state_q != S_IDLE);
  assign tck_o      = tck_q;
  assign tms_o      = tms_q;
  assign tdi_o      = tdi_q;

endmodule

// File: tb/tb_jtag_host.sv
// tb_jtag_host: directed commands with a response scoreboard and a TCK-edge logger driving a simple TDO model.
`timescale 1ns/1ps
module tb_jtag_host;
  localparam int LW = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_type = 2'b00;
  logic [LW-1:0] cmd_len = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        busy, tck, tms, tdi;
  logic        tdo = 1'b0;

  jtag_host #(.CLK_DIV(2), .MAX_LEN(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_type_i(cmd_type),
    .cmd_len_i(cmd_len), .cmd_data_i(cmd_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .busy_o(busy), .tck_o(tck), .tms_o(tms), .tdi_o(tdi), .tdo_i(tdo)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  int rsp_seen = 0;
  time last_rsp_time = 0;
  time hs_time = 0;

  int  rise_total = 0;
  logic tms_log[512];
  logic tdi_log[512];
  time rise_t[512];
  int  rise_base = 0;
  int  pre_len = 0;
  logic [31:0] tdo_vec = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge tck) begin
    tms_log[rise_total] <= tms;
    tdi_log[rise_total] <= tdi;
    rise_t[rise_total]  <= $time;
    rise_total          <= rise_total + 1;
  end

  // TAP-side TDO model: bit j of the shift is presented after the falling edge before its rising edge
  always @(negedge tck) begin
    int j;
    j = rise_total - rise_base - pre_len;
    tdo <= (j >= 0 && j < 32) ? tdo_vec[j] : 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      rsp_seen++;
      last_rsp_time = $time;
      if (exp_q.size() == 0) check("rsp_unexpected", 64'(rsp_data), 64'hFFFF_FFFF_FFFF_FFFF);
      else check("rsp_data", 64'(rsp_data), 64'(exp_q.pop_front()));
    end
  end

  function automatic logic [63:0] tms_bits(input int b, input int n);
    logic [63:0] v = '0;
    for (int k = 0; k < n; k++) v[k] = tms_log[b + k];
    return v;
  endfunction

  function automatic logic [63:0] tdi_bits(input int b, input int n);
    logic [63:0] v = '0;
    for (int k = 0; k < n; k++) v[k] = tdi_log[b + k];
    return v;
  endfunction

  task automatic send_cmd(input string name, input logic [1:0] t, input logic [LW-1:0] len,
                          input logic [31:0] d, input int pre, input logic [31:0] tv);
    bit done = 0;
    @(negedge clk);
    pre_len   = pre;
    tdo_vec   = tv;
    cmd_type  = t;
    cmd_len   = len;
    cmd_data  = d;
    cmd_valid = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      if (cmd_ready) begin
        @(posedge clk);
        rise_base = rise_total;
        hs_time   = $time;
        done      = 1;
      end else begin
        @(negedge clk);
      end
    end
    #1 cmd_valid = 1'b0;
    if (!done) check({name, "_handshake_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    if (!done) check({name, "_idle_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    int b, r0, errs;
    bit ok, got;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data",  64'(rsp_data),  64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_tck",       64'(tck),       64'd0);
    check("rst_tms",       64'(tms),       64'd1);
    check("rst_tdi",       64'(tdi),       64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(cmd_ready), 64'd1);

    // Test 1: TAP reset
    send_cmd("t1", 2'b00, 6'd0, 32'h0, 0, 32'h0);
    wait_idle("t1");
    b = rise_base;
    check("t1_tck_count", 64'(rise_total - b), 64'd6);
    check("t1_tms", tms_bits(b, 6), 64'b011111);
    ok = 1;
    for (int k = 1; k < 6; k++) if (rise_t[b+k] - rise_t[b+k-1] != 40) ok = 0;
    check("t1_tck_period", 64'(ok), 64'd1);
    check("t1_no_rsp", 64'(rsp_seen), 64'd0);
    @(negedge clk);
    check("t1_ready", 64'(cmd_ready), 64'd1);

    // Test 2: IR shift, TDO 0,1,0,1 then ones that must not be captured
    exp_q.push_back(32'h0000_000A);
    send_cmd("t2", 2'b01, 6'd4, 32'h5, 4, 32'hFFFF_FFFA);
    wait_idle("t2");
    b = rise_base;
    check("t2_tck_count", 64'(rise_total - b), 64'd10);
    check("t2_tms", tms_bits(b, 10), 64'b0110000011);
    check("t2_tdi", tdi_bits(b + 4, 4), 64'b0101);
    check("t2_rsp_count", 64'(rsp_seen), 64'd1);

    // Test 3 + 4: DR shift through a bypass bit, response held off for 20 cycles
    @(posedge clk); #1 rsp_ready = 1'b0;
    exp_q.push_back(32'hBD5B_7DDE);
    send_cmd("t3", 2'b10, 6'd32, 32'hDEAD_BEEF, 3, 32'hBD5B_7DDE);
    got = 0;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1;
    end
    check("t3_rsp_valid_seen", 64'(got), 64'd1);
    check("t3_tck_count", 64'(rise_total - rise_base), 64'd37);
    r0 = rise_total;
    errs = 0;
    fork
      send_cmd("t4_queued", 2'b11, 6'd3, 32'h0, 0, 32'h0);
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (rsp_valid !== 1'b1 || rsp_data !== 32'hBD5B_7DDE || cmd_ready !== 1'b0 || tck !== 1'b0) errs++;
        end
        check("t4_hold_stable", 64'(errs), 64'd0);
        check("t4_hold_no_tck", 64'(rise_total - r0), 64'd0);
        @(posedge clk); #1 rsp_ready = 1'b1;
      end
    join
    check("t4_queued_after_rsp", 64'(hs_time > last_rsp_time), 64'd1);
    wait_idle("t4");
    check("t4_idle_tck_count", 64'(rise_total - rise_base), 64'd3);
    check("t4_idle_tms", tms_bits(rise_base, 3), 64'd0);
    check("t4_rsp_count", 64'(rsp_seen), 64'd2);

    // Test 5: reset during bit 10 of a DR shift
    send_cmd("t5", 2'b10, 6'd32, 32'hFFFF_FFFF, 3, 32'hFFFF_FFFF);
    got = 0;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge clk);
      if (rise_total - rise_base >= 14) got = 1;
    end
    check("t5_reached_bit10", 64'(got), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_tck",       64'(tck),       64'd0);
    check("t5_tms",       64'(tms),       64'd1);
    check("t5_tdi",       64'(tdi),       64'd0);
    check("t5_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t5_busy",      64'(busy),      64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_ready_after", 64'(cmd_ready), 64'd1);
    repeat (5) @(negedge clk);
    check("t5_no_rsp", 64'(rsp_seen), 64'd2);

    // Test 6: idle len 0, then DR len 40 clamped to 32
    send_cmd("t6a", 2'b11, 6'd0, 32'h0, 0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("t6_idle0_ready", 64'(cmd_ready), 64'd1);
    check("t6_idle0_no_tck", 64'(rise_total - rise_base), 64'd0);
    exp_q.push_back(32'h1234_5678);
    send_cmd("t6b", 2'b10, 6'd40, 32'h0, 3, 32'h1234_5678);
    wait_idle("t6b");
    check("t6_clamp_tck_count", 64'(rise_total - rise_base), 64'd37);
    check("t6_rsp_count", 64'(rsp_seen), 64'd3);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
